// File: rtl/telemetry_frame_sequencer.sv
// -----------------------------------------------------------------------------
// telemetry_frame_sequencer
//
// Owns the shared async_transmitter and emits one ASCII telemetry frame per
// trigger: "SS AAAA TT BB\r\n" (15 characters, uppercase hex). The fields are
// the frame sequence number, ADC word, DS18B20 temperature byte and
// bill-acceptor count. All field values are captured in one LOAD cycle, so the
// whole frame is a consistent snapshot even if the sensors update mid-frame.
//
// Parameters
//   FRAME_PERIOD  clock cycles between internal triggers (0 disables them)
//   ACK_TIMEOUT   cycles to wait for tx_busy to rise after tx_start before the
//                 character is treated as accepted (must be >= 1)
//
// Ports
//   CLK_10MHZ    in   1   system clock
//   rst_n        in   1   asynchronous reset, active low
//   enable       in   1   0 blocks new frames; a frame in progress completes
//   frame_req    in   1   one-cycle external trigger, ORed with the period trigger
//   adc_data     in  16   ADC sample, captured at LOAD
//   temperature  in   8   temperature byte, captured at LOAD
//   bill_count   in   8   bill-acceptor count, captured at LOAD
//   tx_busy      in   1   TxD_busy from async_transmitter
//   tx_start     out  1   TxD_start, one-cycle pulse per character
//   tx_data      out  8   TxD_data, stable from tx_start until the char completes
//   frame_busy   out  1   high from LOAD through the end of the last character
//   frame_done   out  1   one-cycle pulse after the LF character completes
//   overrun_cnt  out  8   saturating count of triggers dropped while pending
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module telemetry_frame_sequencer #(
    parameter int FRAME_PERIOD = 10000,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic        CLK_10MHZ,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_req,
    input  logic [15:0] adc_data,
    input  logic [7:0]  temperature,
    input  logic [7:0]  bill_count,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [7:0]  overrun_cnt
);

    localparam int PW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int AW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [3:0] LAST_IDX = 4'd14;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_ACK,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_period_cnt;
    logic [AW-1:0]   r_ack_cnt;
    logic [3:0]      r_idx;
    logic [7:0]      r_seq;
    logic            r_pending;
    logic [7:0]      r_overrun;
    logic [15:0]     r_adc_s;
    logic [7:0]      r_temp_s;
    logic [7:0]      r_bill_s;

    logic            w_int_trig;
    logic            w_trig;
    logic            w_go;
    logic            w_char_done;
    logic            w_tx_start;
    logic            w_frame_done;
    logic [7:0]      w_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // ------------------------------------------------------------------
    // Trigger generation and acceptance
    // ------------------------------------------------------------------
    assign w_int_trig = (FRAME_PERIOD != 0) && (r_period_cnt == PW'(FRAME_PERIOD - 1));
    // A coincident frame_req and period wrap collapse into one trigger here.
    assign w_trig     = frame_req | w_int_trig;
    assign w_go       = (r_state == S_IDLE) && enable && (w_trig || r_pending);
    assign frame_busy = (r_state != S_IDLE);

    // NOTE: every register, including the field shadow copies, sits on the
    // async reset so a mid-frame reset leaves nothing stale behind; all
    // sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_period_cnt <= '0;
        end else if ((FRAME_PERIOD == 0) || w_int_trig) begin
            r_period_cnt <= '0;
        end else begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    // A trigger during a frame is remembered once; any further trigger while
    // one is already remembered is lost and counted.
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_overrun <= '0;
        end else begin
            if (w_go) begin
                r_pending <= 1'b0;
            end else if (w_trig && frame_busy) begin
                r_pending <= 1'b1;
            end
            if (w_trig && r_pending && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_char_done = (r_state == S_DONE) && !tx_busy;

    // NOTE: defaults first so no path through the case leaves an output
    // unassigned and infers a latch.
    always_comb begin
        w_state_nxt  = r_state;
        w_tx_start   = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    w_tx_start  = 1'b1;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                // A transmitter that never shows busy must not stall the frame.
                if (tx_busy || (r_ack_cnt == AW'(ACK_TIMEOUT - 1))) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (w_char_done) begin
                    if (r_idx == LAST_IDX) begin
                        w_frame_done = 1'b1;
                        w_state_nxt  = S_IDLE;
                    end else begin
                        w_state_nxt  = S_SEND;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: snapshot, character index, ACK timer, sequence number
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
        if (!rst_n) begin
            r_adc_s   <= '0;
            r_temp_s  <= '0;
            r_bill_s  <= '0;
            r_idx     <= '0;
            r_ack_cnt <= '0;
            r_seq     <= '0;
        end else begin
            if (r_state == S_LOAD) begin
                r_adc_s  <= adc_data;
                r_temp_s <= temperature;
                r_bill_s <= bill_count;
                r_idx    <= '0;
            end else if (w_char_done && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + 1'b1;
            end

            if (r_state == S_ACK) begin
                r_ack_cnt <= r_ack_cnt + 1'b1;
            end else begin
                r_ack_cnt <= '0;
            end

            // r_seq only changes as a frame ends, so it needs no shadow copy.
            if (w_frame_done) begin
                r_seq <= r_seq + 1'b1;
            end
        end
    end

    always_comb begin
        w_char = 8'h00;
        case (r_idx)
            4'd0:    w_char = hex_char(r_seq[7:4]);
            4'd1:    w_char = hex_char(r_seq[3:0]);
            4'd3:    w_char = hex_char(r_adc_s[15:12]);
            4'd4:    w_char = hex_char(r_adc_s[11:8]);
            4'd5:    w_char = hex_char(r_adc_s[7:4]);
            4'd6:    w_char = hex_char(r_adc_s[3:0]);
            4'd8:    w_char = hex_char(r_temp_s[7:4]);
            4'd9:    w_char = hex_char(r_temp_s[3:0]);
            4'd11:   w_char = hex_char(r_bill_s[7:4]);
            4'd12:   w_char = hex_char(r_bill_s[3:0]);
            4'd2,
            4'd7,
            4'd10:   w_char = 8'h20;
            4'd13:   w_char = 8'h0D;
            4'd14:   w_char = 8'h0A;
            default: w_char = 8'h00;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx_start    = w_tx_start;
    assign frame_done  = w_frame_done;
    assign overrun_cnt = r_overrun;
    // r_idx is constant from SEND through DONE, which keeps tx_data stable
    // for the whole character.
    assign tx_data     = ((r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_DONE))
                         ? w_char : 8'h00;

endmodule

// File: tb/tb_telemetry_frame_sequencer.sv
`timescale 1ns/1ps

module tb_telemetry_frame_sequencer;

    logic        clk = 1'b0;
    always #50 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        frame_req = 1'b0;
    logic [15:0] adc_data = '0;
    logic [7:0]  temperature = '0;
    logic [7:0]  bill_count = '0;
    logic        tx_busy = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        frame_busy;
    logic        frame_done;
    logic [7:0]  overrun_cnt;

    // Second instance exercises the internal period trigger.
    logic        en_p = 1'b1;
    logic        req_p = 1'b0;
    logic        busy_p = 1'b0;
    logic        tx_start_p;
    logic [7:0]  tx_data_p;
    logic        frame_busy_p;
    logic        frame_done_p;
    logic [7:0]  overrun_cnt_p;

    telemetry_frame_sequencer #(.FRAME_PERIOD(0), .ACK_TIMEOUT(15)) dut (
        .CLK_10MHZ  (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame_req  (frame_req),
        .adc_data   (adc_data),
        .temperature(temperature),
        .bill_count (bill_count),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .frame_busy (frame_busy),
        .frame_done (frame_done),
        .overrun_cnt(overrun_cnt)
    );

    telemetry_frame_sequencer #(.FRAME_PERIOD(40), .ACK_TIMEOUT(15)) dut_p (
        .CLK_10MHZ  (clk),
        .rst_n      (rst_n),
        .enable     (en_p),
        .frame_req  (req_p),
        .adc_data   (adc_data),
        .temperature(temperature),
        .bill_count (bill_count),
        .tx_busy    (busy_p),
        .tx_start   (tx_start_p),
        .tx_data    (tx_data_p),
        .frame_busy (frame_busy_p),
        .frame_done (frame_done_p),
        .overrun_cnt(overrun_cnt_p)
    );

    // Transmitter model: 0 = normal (busy 3 cycles per char), 1 = busy stuck
    // low, 2 = busy stuck high.
    int mode = 0;
    int busy_cnt = 0;
    always @(posedge clk) begin
        case (mode)
            0: begin
                if (tx_start) begin
                    busy_cnt <= 3;
                    tx_busy  <= 1'b1;
                end else if (busy_cnt > 1) begin
                    busy_cnt <= busy_cnt - 1;
                end else begin
                    busy_cnt <= 0;
                    tx_busy  <= 1'b0;
                end
            end
            1: begin
                busy_cnt <= 0;
                tx_busy  <= 1'b0;
            end
            default: begin
                busy_cnt <= 0;
                tx_busy  <= 1'b1;
            end
        endcase
    end

    // Monitor of the transmit interface of the main instance.
    logic [7:0] q[$];
    int n_start = 0;
    int n_done = 0;
    int cyc = 0;
    int last_start = -1000;
    int last_gap = 0;
    int n_viol = 0;
    always @(negedge clk) begin
        cyc++;
        if (tx_start) begin
            if (tx_busy) n_viol++;
            if (cyc - last_start < 3) n_viol++;
            last_gap   = cyc - last_start;
            last_start = cyc;
            q.push_back(tx_data);
            n_start++;
        end
        if (frame_done) n_done++;
    end

    int n_tests = 0;
    int n_fail = 0;

    task automatic check_int(input string name, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_str(input string name, input logic [119:0] got, input logic [119:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [119:0] exp_str(input logic [103:0] t);
        return {t, 8'h0D, 8'h0A};
    endfunction

    task automatic clear_mon();
        q.delete();
        n_start    = 0;
        n_done     = 0;
        last_start = -1000;
        last_gap   = 0;
    endtask

    task automatic pulse_req();
        @(negedge clk);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_int(name, int'(n_done >= target), 1);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic get_str(input int off, output logic [119:0] s);
        s = '0;
        for (int i = 0; i < 15; i++) begin
            s = {s[111:0], (off + i < q.size()) ? q[off + i] : 8'h00};
        end
    endtask

    task automatic run_frame(input string name, input logic [103:0] txt, input bit perturb);
        logic [119:0] s;
        clear_mon();
        pulse_req();
        if (perturb) begin
            repeat (3) @(negedge clk);
            adc_data    = 16'hFFFF;
            temperature = 8'h00;
            bill_count  = 8'h00;
        end
        wait_done(1, 3000, {name, " done"});
        settle();
        get_str(0, s);
        check_str({name, " text"}, s, exp_str(txt));
        check_int({name, " frame_done pulses"}, n_done, 1);
        check_int({name, " tx_start pulses"}, n_start, 15);
    endtask

    typedef struct {
        logic [15:0]  adc;
        logic [7:0]   temp;
        logic [7:0]   bill;
        logic [103:0] txt;
    } vec_t;

    vec_t vt[4];

    initial begin
        logic [119:0] s;
        int first_p;
        int idle_starts;
        int idle_busy;
        int k;

        vt[0] = '{adc: 16'h1A2F, temp: 8'h19, bill: 8'h03, txt: "00 1A2F 19 03"};
        vt[1] = '{adc: 16'hBEEF, temp: 8'h7F, bill: 8'hA5, txt: "01 BEEF 7F A5"};
        vt[2] = '{adc: 16'h0000, temp: 8'h00, bill: 8'hFF, txt: "02 0000 00 FF"};
        vt[3] = '{adc: 16'h9A5C, temp: 8'hE0, bill: 8'h10, txt: "03 9A5C E0 10"};

        // Reset state
        enable = 1'b1;
        repeat (3) @(negedge clk);
        check_int("reset tx_start", int'(tx_start), 0);
        check_int("reset tx_data", int'(tx_data), 0);
        check_int("reset frame_busy", int'(frame_busy), 0);
        check_int("reset frame_done", int'(frame_done), 0);
        check_int("reset overrun_cnt", int'(overrun_cnt), 0);

        // Idle with no trigger source; period instance fires at its wrap
        rst_n = 1'b1;
        first_p = 0;
        idle_starts = 0;
        idle_busy = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (tx_start_p && first_p == 0) first_p = c;
            if (tx_start) idle_starts++;
            if (frame_busy) idle_busy++;
        end
        check_int("idle tx_start count", idle_starts, 0);
        check_int("idle frame_busy cycles", idle_busy, 0);
        check_int("period first tx_start cycle", first_p, 41);

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            adc_data    = vt[i].adc;
            temperature = vt[i].temp;
            bill_count  = vt[i].bill;
            run_frame($sformatf("table frame %0d", i), vt[i].txt, 1'b0);
        end

        // Snapshot: fields change after LOAD
        adc_data    = 16'h1A2F;
        temperature = 8'h19;
        bill_count  = 8'h03;
        run_frame("snapshot", "04 1A2F 19 03", 1'b1);

        // Overrun: starting pulse plus two during the frame
        adc_data    = 16'h0A0B;
        temperature = 8'hC1;
        bill_count  = 8'h2D;
        clear_mon();
        pulse_req();
        repeat (20) @(negedge clk);
        pulse_req();
        repeat (20) @(negedge clk);
        pulse_req();
        wait_done(2, 5000, "overrun follow-on done");
        repeat (200) @(negedge clk);
        #1;
        check_int("overrun frame count", n_done, 2);
        check_int("overrun tx_start count", n_start, 30);
        check_int("overrun_cnt", int'(overrun_cnt), 1);
        get_str(0, s);
        check_str("overrun first text", s, exp_str("05 0A0B C1 2D"));
        get_str(15, s);
        check_str("overrun follow-on text", s, exp_str("06 0A0B C1 2D"));

        // enable low mid-frame: frame completes, pending held until enable
        adc_data    = 16'hC0DE;
        temperature = 8'h42;
        bill_count  = 8'h07;
        clear_mon();
        pulse_req();
        repeat (5) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        pulse_req();
        wait_done(1, 3000, "enable-low frame done");
        repeat (100) @(negedge clk);
        #1;
        check_int("enable-low no new frame", n_done, 1);
        check_int("enable-low frame_busy", int'(frame_busy), 0);
        get_str(0, s);
        check_str("enable-low text", s, exp_str("07 C0DE 42 07"));
        enable = 1'b1;
        wait_done(2, 3000, "pending served");
        settle();
        get_str(15, s);
        check_str("pending frame text", s, exp_str("08 C0DE 42 07"));

        // Timeout: busy never rises
        adc_data    = 16'h0123;
        temperature = 8'h45;
        bill_count  = 8'h67;
        mode = 1;
        run_frame("timeout", "09 0123 45 67", 1'b0);
        check_int("timeout char spacing", last_gap, 17);

        // Busy stuck high: nothing sent until it drops
        mode = 2;
        clear_mon();
        pulse_req();
        repeat (200) @(negedge clk);
        #1;
        check_int("stuck-busy tx_start count", n_start, 0);
        check_int("stuck-busy frame_busy", int'(frame_busy), 1);
        mode = 0;
        wait_done(1, 3000, "stuck-busy recovery done");
        settle();
        get_str(0, s);
        check_str("stuck-busy recovery text", s, exp_str("0A 0123 45 67"));

        // Sequence number wrap
        for (int f = 11; f < 255; f++) begin
            clear_mon();
            pulse_req();
            wait_done(1, 3000, "wrap frame done");
        end
        settle();
        run_frame("seq FF", "FF 0123 45 67", 1'b0);
        run_frame("seq wrap", "00 0123 45 67", 1'b0);

        // Reset while the idx 6 character is being started
        clear_mon();
        pulse_req();
        k = 0;
        while (n_start < 7 && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_int("reached idx 6", n_start, 7);
        check_int("idx 6 tx_start", int'(tx_start), 1);
        check_int("idx 6 tx_data", int'(tx_data), 8'h33);
        rst_n = 1'b0;
        #1;
        check_int("mid-reset tx_start", int'(tx_start), 0);
        check_int("mid-reset tx_data", int'(tx_data), 0);
        check_int("mid-reset frame_busy", int'(frame_busy), 0);
        check_int("mid-reset overrun_cnt", int'(overrun_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        run_frame("after reset", "00 0123 45 67", 1'b0);

        check_int("tx_start spacing/busy violations", n_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
